// File: rtl/lc3_mem_unit.sv
// LC-3 memory subsystem: MAR/MDR registers, word-addressed RAM and a
// wait-state sequencer that raises memReady on the edge an access completes.
module lc3_mem_unit #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ldMAR,
  input  logic                  ldMDR,
  input  logic                  selMDR,
  input  logic                  memWE,
  input  logic                  enaMDR,
  input  logic [15:0]           busIn,
  output logic [15:0]           mdrOut,
  output logic                  mdrDrive,
  output logic [15:0]           marOut,
  output logic                  memReady,
  input  logic                  progWE,
  input  logic [DEPTH_LOG2-1:0] progAddr,
  input  logic [15:0]           progData
);

  // Handshake: a request (read or write) is held by the controller and is
  // taken at the first clock edge where req & memReady; dropping it early aborts.
  localparam bit         WS_ZERO  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     mar_q, mdr_q;
  logic [15:0]     ram_q [2**DEPTH_LOG2];
  logic            read_req, write_req, req, complete, mem_ready;
  logic [DEPTH_LOG2-1:0] addr;

  assign read_req  = ldMDR & selMDR;
  assign write_req = memWE;
  assign req       = read_req | write_req;
  assign addr      = mar_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_ready = 1'b1;
    case (state_q)
      S_IDLE: begin
        mem_ready = !req || WS_ZERO;
        if (req && !WS_ZERO) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        mem_ready = (cnt_q == 4'd0);
        if (!req || cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      mem_ready = 1'b1;
    end
  end

  // Reset discards any pending access, so completion is gated here.
  assign complete = req && mem_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ldMAR) begin
        mar_q <= busIn;
      end
      // A write wins over a simultaneous read, so RAM never loads MDR then.
      if (complete && read_req && !write_req) begin
        mdr_q <= ram_q[addr];
      end else if (ldMDR && !selMDR) begin
        mdr_q <= busIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (progWE) begin
        ram_q[progAddr] <= progData;
      end
    end else if (complete && write_req) begin
      ram_q[addr] <= mdr_q;
    end
  end

  assign mdrOut   = enaMDR ? mdr_q : 16'h0000;
  assign mdrDrive = enaMDR;
  assign marOut   = mar_q;
  assign memReady = mem_ready;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Bench for lc3_mem_unit: one zero-wait instance driven from a vector table,
// one three-wait instance exercised by hand-written multi-cycle sequences.
module tb_lc3_mem_unit;

  logic        clk = 1'b0;
  logic        reset, ldMAR, ldMDR, selMDR, memWE, enaMDR, progWE;
  logic [15:0] busIn, progData;
  logic [7:0]  progAddr;
  logic [15:0] mdr_out0, mar_out0, mdr_out3, mar_out3;
  logic        mdr_drive0, mem_ready0, mdr_drive3, mem_ready3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3_mem_unit #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
    .memWE(memWE), .enaMDR(enaMDR), .busIn(busIn), .mdrOut(mdr_out0),
    .mdrDrive(mdr_drive0), .marOut(mar_out0), .memReady(mem_ready0),
    .progWE(progWE), .progAddr(progAddr), .progData(progData)
  );

  lc3_mem_unit #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
    .memWE(memWE), .enaMDR(enaMDR), .busIn(busIn), .mdrOut(mdr_out3),
    .mdrDrive(mdr_drive3), .marOut(mar_out3), .memReady(mem_ready3),
    .progWE(progWE), .progAddr(progAddr), .progData(progData)
  );

  typedef struct {
    logic        lm, ld, sel, we, prog;
    logic [15:0] bus, exp_mar, exp_mdr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic lm, logic ld, logic sel, logic we, logic prog,
                              logic [15:0] bus, logic [15:0] emar, logic [15:0] emdr);
    vec_t v;
    v.lm = lm; v.ld = ld; v.sel = sel; v.we = we; v.prog = prog;
    v.bus = bus; v.exp_mar = emar; v.exp_mdr = emdr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0; enaMDR = 0;
    busIn = 16'h0; progWE = 0; progAddr = 8'h0; progData = 16'h0;
  endtask

  task automatic drive(input logic lm, input logic ld, input logic sel,
                       input logic we, input logic [15:0] bus);
    ldMAR = lm; ldMDR = ld; selMDR = sel; memWE = we; busIn = bus;
  endtask

  // Finish a cycle: wait for the edge, drop controls, expose MDR on the bus.
  task automatic edge_then_peek();
    @(posedge clk);
    #1;
    clr();
    enaMDR = 1'b1;
    #1;
  endtask

  // One three-wait cycle: check memReady before the edge, MDR after it.
  task automatic cyc3(input string name, input logic lm, input logic ld,
                      input logic sel, input logic we, input logic [15:0] bus,
                      input logic exp_rdy, input logic [15:0] exp_mdr);
    @(negedge clk);
    drive(lm, ld, sel, we, bus);
    #1;
    chk({name, "_ready"}, {15'h0, mem_ready3}, {15'h0, exp_rdy});
    edge_then_peek();
    chk({name, "_mdr"}, mdr_out3, exp_mdr);
  endtask

  initial begin
    clr();
    reset = 1'b1;

    // Reset phase: preload code/data, check reset-state outputs.
    @(negedge clk);
    progWE = 1; progAddr = 8'h05; progData = 16'h1234;
    @(negedge clk);
    progAddr = 8'h07; progData = 16'h7777;
    @(negedge clk);
    progAddr = 8'h02; progData = 16'h2222;
    @(negedge clk);
    clr();
    memWE = 1'b1;
    #1;
    chk("rst_ready0", {15'h0, mem_ready0}, 16'h0001);
    chk("rst_ready3", {15'h0, mem_ready3}, 16'h0001);
    chk("rst_mar", mar_out0, 16'h0000);
    chk("rst_mdrout_off", mdr_out0, 16'h0000);
    chk("rst_drive_off", {15'h0, mdr_drive0}, 16'h0000);
    memWE = 1'b0;
    enaMDR = 1'b1;
    #1;
    chk("rst_mdrout_on", mdr_out0, 16'h0000);
    chk("rst_drive_on", {15'h0, mdr_drive0}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    clr();

    //              lm ld sel we prg bus       mar       mdr
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0005, 16'h0005, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0005, 16'h1234));
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0009, 16'h0009, 16'h1234));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'hBEEF, 16'h0009, 16'hBEEF));
    vt.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0009, 16'hBEEF));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0009, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0009, 16'hBEEF));
    // write with ldMAR at the same edge uses old MAR (2), not 7
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0002, 16'h0002, 16'hBEEF));
    vt.push_back(mk(1, 0, 0, 1, 0, 16'h0007, 16'h0007, 16'hBEEF));
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0002, 16'h0002, 16'hBEEF));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0002, 16'hBEEF));
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0007, 16'h0007, 16'hBEEF));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0007, 16'h7777));
    // write with bus load of MDR at the same edge stores old MDR
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h00AA, 16'h0007, 16'h00AA));
    vt.push_back(mk(0, 1, 0, 1, 0, 16'h0001, 16'h0007, 16'h0001));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0007, 16'h00AA));
    // aliasing: 0x0105 and 0x0005 share a word
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0105, 16'h0105, 16'h00AA));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'hCAFE, 16'h0105, 16'hCAFE));
    vt.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 16'h0105, 16'hCAFE));
    vt.push_back(mk(1, 0, 0, 0, 0, 16'h0005, 16'h0005, 16'hCAFE));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0005, 16'hCAFE));
    // illegal read+write: write wins, MDR not loaded from RAM
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h5A5A, 16'h0005, 16'h5A5A));
    vt.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'h0005, 16'h5A5A));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0005, 16'h5A5A));
    // program-load write outside reset is ignored
    vt.push_back(mk(0, 0, 0, 0, 1, 16'h0005, 16'h0005, 16'h5A5A));
    vt.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000));
    vt.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0005, 16'h5A5A));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].lm, vt[i].ld, vt[i].sel, vt[i].we, vt[i].bus);
      if (vt[i].prog) begin
        progWE = 1'b1; progAddr = vt[i].bus[7:0]; progData = 16'hDEAD;
      end
      #1;
      chk($sformatf("v%0d_ready", i), {15'h0, mem_ready0}, 16'h0001);
      edge_then_peek();
      chk($sformatf("v%0d_mar", i), mar_out0, vt[i].exp_mar);
      chk($sformatf("v%0d_mdr", i), mdr_out0, vt[i].exp_mdr);
    end

    // Three-wait instance: fresh reset, then multi-cycle sequences.
    @(negedge clk);
    clr();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc3("w_setmar", 1, 0, 0, 0, 16'h0005, 1'b1, 16'h0000);
    chk("w_mar", mar_out3, 16'h0005);
    cyc3("rd0", 0, 1, 1, 0, 16'h0, 1'b0, 16'h0000);
    cyc3("rd1", 0, 1, 1, 0, 16'h0, 1'b0, 16'h0000);
    cyc3("rd2", 0, 1, 1, 0, 16'h0, 1'b0, 16'h0000);
    cyc3("rd3", 0, 1, 1, 0, 16'h0, 1'b1, 16'h1234);
    cyc3("ldbus", 0, 1, 0, 0, 16'hBEEF, 1'b1, 16'hBEEF);
    cyc3("wr0", 0, 0, 0, 1, 16'h0, 1'b0, 16'hBEEF);
    cyc3("wr1", 0, 0, 0, 1, 16'h0, 1'b0, 16'hBEEF);
    cyc3("wr2", 0, 0, 0, 1, 16'h0, 1'b0, 16'hBEEF);
    cyc3("wr3", 0, 0, 0, 1, 16'h0, 1'b1, 16'hBEEF);
    cyc3("clr", 0, 1, 0, 0, 16'h0000, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      cyc3($sformatf("rb%0d", k), 0, 1, 1, 0, 16'h0, (k == 3), (k == 3) ? 16'hBEEF : 16'h0000);
    end

    // Abort: write dropped after two cycles leaves RAM untouched.
    cyc3("ab_ld", 0, 1, 0, 0, 16'h1357, 1'b1, 16'h1357);
    cyc3("ab_w0", 0, 0, 0, 1, 16'h0, 1'b0, 16'h1357);
    cyc3("ab_w1", 0, 0, 0, 1, 16'h0, 1'b0, 16'h1357);
    @(negedge clk);
    clr();
    @(negedge clk);
    #1;
    chk("ab_idle_ready", {15'h0, mem_ready3}, 16'h0001);
    cyc3("ab_clr", 0, 1, 0, 0, 16'h0000, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      cyc3($sformatf("ab_rb%0d", k), 0, 1, 1, 0, 16'h0, (k == 3), (k == 3) ? 16'hBEEF : 16'h0000);
    end

    // Reset mid-WAIT discards the pending write and clears MAR/MDR.
    cyc3("rw_ld", 0, 1, 0, 0, 16'h4444, 1'b1, 16'h4444);
    cyc3("rw_w0", 0, 0, 0, 1, 16'h0, 1'b0, 16'h4444);
    cyc3("rw_w1", 0, 0, 0, 1, 16'h0, 1'b0, 16'h4444);
    @(negedge clk);
    drive(0, 0, 0, 1, 16'h0);
    reset = 1'b1;
    #1;
    chk("rw_rst_ready", {15'h0, mem_ready3}, 16'h0001);
    edge_then_peek();
    chk("rw_rst_mdr", mdr_out3, 16'h0000);
    chk("rw_rst_mar", mar_out3, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc3("rw_setmar", 1, 0, 0, 0, 16'h0005, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      cyc3($sformatf("rw_rb%0d", k), 0, 1, 1, 0, 16'h0, (k == 3), (k == 3) ? 16'hBEEF : 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
